// File: rtl/cp0_timer_unit.sv
// Coprocessor 0 for the pipelined MIPS core: SR/Cause/EPC/PrID/BadVAddr plus Count/Compare
// with a timer interrupt on IP[7]. Entry/eret are decided combinationally from the M stage.
module cp0_timer_unit #(
  parameter int unsigned NUM_HWINT = 5,
  parameter logic [31:0] PRID      = 32'hbaad_face,
  parameter int unsigned TIMER_EN  = 1,
  parameter int unsigned COUNT_DIV = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [31:0]          i_mpc,
  input  logic                 i_mbd,
  input  logic [1:0]           i_op,
  input  logic [4:0]           i_regid,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata,
  input  logic [NUM_HWINT-1:0] i_hwint,
  input  logic [4:0]           i_exc_code,
  input  logic [31:0]          i_bad_vaddr,
  output logic [31:0]          o_epc,
  output logic [1:0]           o_exl_op,
  output logic                 o_timer_irq
);

  localparam logic [1:0] OpMfc0 = 2'b01;
  localparam logic [1:0] OpMtc0 = 2'b10;
  localparam logic [1:0] OpEret = 2'b11;
  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic TimerOn = (TIMER_EN != 0);

  function automatic logic [5:0] f_im_impl();
    logic [5:0] m;
    m = '0;
    for (int i = 0; i < int'(NUM_HWINT); i++) m[i] = 1'b1;
    m[5] = TimerOn;
    return m;
  endfunction

  // IM[7:2] bits that correspond to wired interrupt sources
  localparam logic [5:0] ImImpl = f_im_impl();

  logic [5:0]    r_im;
  logic [5:0]    r_ip;
  logic          r_exl;
  logic          r_ie;
  logic          r_bd;
  logic [4:0]    r_exc_code;
  logic [31:0]   r_epc;
  logic [31:0]   r_bad_vaddr;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic          r_ti;
  logic [PW-1:0] r_pre;

  logic [5:0]  w_ip_now;
  logic        w_interrupt;
  logic        w_exception;
  logic        w_entry;
  logic        w_eret;
  logic        w_mtc0;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_tick;
  logic [31:0] w_epc_next;

  always_comb begin
    w_ip_now                  = '0;
    w_ip_now[NUM_HWINT-1:0]   = i_hwint;
    w_ip_now[5]               = r_ti & TimerOn;
  end

  assign w_interrupt  = (|(r_im & w_ip_now)) & r_ie & ~r_exl;
  assign w_exception  = |i_exc_code;
  assign w_entry      = w_interrupt | w_exception;
  assign w_eret       = (i_op == OpEret) & ~w_entry;
  assign w_mtc0       = (i_op == OpMtc0) & ~w_entry;
  assign w_wr_count   = w_mtc0 & (i_regid == 5'd9) & TimerOn;
  assign w_wr_compare = w_mtc0 & (i_regid == 5'd11) & TimerOn;
  assign w_tick       = (r_pre == PW'(COUNT_DIV - 1));
  // Delay-slot instructions restart at the branch
  assign w_epc_next   = (i_mbd ? i_mpc - 32'd4 : i_mpc) & 32'hffff_fffc;

  assign o_epc       = r_epc;
  assign o_timer_irq = r_ti;

  always_comb begin
    o_exl_op = 2'b00;
    if (!i_reset) begin
      if (w_entry) o_exl_op = 2'b01;
      else if (i_op == OpEret) o_exl_op = 2'b10;
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    if (!i_reset && i_op == OpMfc0) begin
      case (i_regid)
        5'd8:    o_rdata = r_bad_vaddr;
        5'd9:    o_rdata = TimerOn ? r_count : 32'd0;
        5'd11:   o_rdata = TimerOn ? r_compare : 32'd0;
        5'd12:   o_rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
        5'd13:   o_rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
        5'd14:   o_rdata = r_epc;
        5'd15:   o_rdata = PRID;
        default: o_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_im        <= ImImpl;
      r_ip        <= '0;
      r_exl       <= 1'b0;
      r_ie        <= 1'b1;
      r_bd        <= 1'b0;
      r_exc_code  <= '0;
      r_epc       <= '0;
      r_bad_vaddr <= '0;
    end else begin
      r_ip <= w_ip_now;
      if (w_entry) begin
        r_exl      <= 1'b1;
        r_exc_code <= w_interrupt ? 5'd0 : i_exc_code;
        // A nested exception must not lose the original return point
        if (!r_exl) begin
          r_bd  <= i_mbd;
          r_epc <= w_epc_next;
        end
        if (!w_interrupt && (i_exc_code == 5'd4 || i_exc_code == 5'd5)) begin
          r_bad_vaddr <= i_bad_vaddr;
        end
      end else if (w_eret) begin
        r_exl      <= 1'b0;
        r_exc_code <= '0;
        r_bd       <= 1'b0;
      end else if (w_mtc0) begin
        case (i_regid)
          5'd12: begin
            r_im  <= i_wdata[15:10] & ImImpl;
            r_exl <= i_wdata[1];
            r_ie  <= i_wdata[0];
          end
          5'd14:   r_epc <= i_wdata & 32'hffff_fffc;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count   <= '0;
      r_compare <= 32'hffff_ffff;
      r_ti      <= 1'b0;
      r_pre     <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_wr_count) r_count <= i_wdata;
      else if (w_tick) r_count <= r_count + 32'd1;
      if (w_wr_compare) r_compare <= i_wdata;
      // Compare write acknowledges; a Count write masks the match for that cycle
      if (w_wr_compare) r_ti <= 1'b0;
      else if (!w_wr_count && TimerOn && r_count == r_compare) r_ti <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cp0_timer_unit.sv
// Scoreboard bench for cp0_timer_unit: driver pushes model expectations, monitor checks them.
module tb_cp0_timer_unit;

  localparam logic [31:0] Prid = 32'hbaad_face;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mpc = '0;
  logic        mbd = 1'b0;
  logic [1:0]  op = '0;
  logic [4:0]  regid = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  hwint = '0;
  logic [4:0]  exc_code = '0;
  logic [31:0] bad_vaddr = '0;
  logic [31:0] rdata;
  logic [31:0] epc;
  logic [1:0]  exl_op;
  logic        timer_irq;

  always #5 clk = ~clk;

  cp0_timer_unit #(
    .NUM_HWINT(5),
    .PRID     (Prid),
    .TIMER_EN (1),
    .COUNT_DIV(1)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_mpc      (mpc),
    .i_mbd      (mbd),
    .i_op       (op),
    .i_regid    (regid),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .i_hwint    (hwint),
    .i_exc_code (exc_code),
    .i_bad_vaddr(bad_vaddr),
    .o_epc      (epc),
    .o_exl_op   (exl_op),
    .o_timer_irq(timer_irq)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] epc;
    logic [1:0]  exl_op;
    logic        ti;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;

  // Architectural state of the reference model
  logic [5:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_bva, m_count, m_cmp;

  task automatic model_reset();
    m_im = 6'h3f; m_ip = '0; m_exl = 0; m_ie = 1; m_bd = 0; m_ti = 0;
    m_exc = '0; m_epc = '0; m_bva = '0; m_count = '0; m_cmp = 32'hffff_ffff;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] rid);
    case (rid)
      5'd8:    return m_bva;
      5'd9:    return m_count;
      5'd11:   return m_cmp;
      5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_exc) << 2);
      5'd14:   return m_epc;
      5'd15:   return Prid;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus; the model's expectation for this cycle goes to the scoreboard.
  task automatic drive(input logic rst, input logic [1:0] o, input logic [4:0] rid,
                       input logic [31:0] wd, input logic [4:0] hw, input logic [4:0] ex,
                       input logic [31:0] bva, input logic [31:0] pc, input logic mb);
    exp_t e;
    logic [5:0] ipn;
    logic irq, ent, acc, match;
    @(posedge clk);
    #1;
    reset = rst; op = o; regid = rid; wdata = wd; hwint = hw;
    exc_code = ex; bad_vaddr = bva; mpc = pc; mbd = mb;
    if (rst) begin
      model_reset();
      e = '0;
      sb.push_back(e);
      return;
    end
    ipn = {m_ti, hw};
    irq = ((m_im & ipn) != 0) && m_ie && !m_exl;
    ent = irq || (ex != 0);
    e.exl_op = ent ? 2'd1 : (o == 2'd3) ? 2'd2 : 2'd0;
    e.rdata  = (o == 2'd1) ? model_read(rid) : 32'd0;
    e.epc    = m_epc;
    e.ti     = m_ti;
    sb.push_back(e);
    match = (m_count == m_cmp);
    acc = (o == 2'd2) && !ent;
    m_ip = ipn;
    if (ent) begin
      if (!m_exl) begin
        m_bd  = mb;
        m_epc = (mb ? pc - 32'd4 : pc) & 32'hffff_fffc;
      end
      m_exl = 1;
      m_exc = irq ? 5'd0 : ex;
      if (!irq && (ex == 5'd4 || ex == 5'd5)) m_bva = bva;
    end else if (o == 2'd3) begin
      m_exl = 0; m_exc = 0; m_bd = 0;
    end else if (acc && rid == 5'd12) begin
      m_im = wd[15:10]; m_exl = wd[1]; m_ie = wd[0];
    end else if (acc && rid == 5'd14) begin
      m_epc = wd & 32'hffff_fffc;
    end
    if (acc && rid == 5'd11) begin
      m_cmp = wd;
      m_ti  = 0;
    end else if (!(acc && rid == 5'd9) && match) begin
      m_ti = 1;
    end
    m_count = (acc && rid == 5'd9) ? wd : m_count + 32'd1;
  endtask

  task automatic mfc0(input logic [4:0] rid);
    drive(0, 2'd1, rid, 32'd0, 5'd0, 5'd0, 32'd0, 32'h100, 0);
  endtask

  task automatic mtc0(input logic [4:0] rid, input logic [31:0] d);
    drive(0, 2'd2, rid, d, 5'd0, 5'd0, 32'd0, 32'h104, 0);
  endtask

  task automatic eret();
    drive(0, 2'd3, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'h108, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rdata", rdata, e.rdata);
      chk("epc", epc, e.epc);
      chk("exl_op", 32'(exl_op), 32'(e.exl_op));
      chk("timer_irq", 32'(timer_irq), 32'(e.ti));
    end
  end

  initial begin
    logic [4:0] rtab [9];
    exp_t z;
    rtab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd3};
    model_reset();

    // Reset state, including outputs forced low while reset is held
    drive(1, 2'd1, 5'd15, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 0);
    mfc0(12); mfc0(13); mfc0(14); mfc0(15); mfc0(8); mfc0(11);

    // Hardware interrupt entry, then held line must not re-enter
    drive(0, 2'd0, 5'd0, 32'd0, 5'd1, 5'd0, 32'd0, 32'h3010, 0);
    drive(0, 2'd1, 5'd14, 32'd0, 5'd1, 5'd0, 32'd0, 32'h3014, 0);
    drive(0, 2'd1, 5'd13, 32'd0, 5'd1, 5'd0, 32'd0, 32'h3018, 0);
    drive(0, 2'd1, 5'd12, 32'd0, 5'd1, 5'd0, 32'd0, 32'h301c, 0);
    eret();

    // Address error in a delay slot, then nested exception keeps EPC/BD
    drive(0, 2'd0, 5'd0, 32'd0, 5'd0, 5'd4, 32'h1235, 32'h3008, 1);
    mfc0(14); mfc0(13); mfc0(8);
    drive(0, 2'd0, 5'd0, 32'd0, 5'd0, 5'd10, 32'h9999, 32'h4000, 0);
    mfc0(14); mfc0(13); mfc0(8);
    eret();

    // Timer match and Compare acknowledge
    mtc0(11, 32'd5);
    mtc0(9, 32'd0);
    for (int i = 0; i < 10; i++) mfc0(9);
    mfc0(13);
    mtc0(11, 32'h8000_0000);
    mfc0(13);
    eret();

    // ERET loses to interrupt; MTC0 loses to nested exception
    drive(0, 2'd3, 5'd0, 32'd0, 5'd2, 5'd0, 32'd0, 32'h5000, 0);
    drive(0, 2'd2, 5'd12, 32'd0, 5'd0, 5'd12, 32'd0, 32'h5004, 0);
    mfc0(12); mfc0(13); mfc0(14);
    eret();

    // Async reset in the middle of an entry cycle
    @(posedge clk);
    #1;
    reset = 0; op = 2'd1; regid = 5'd12; hwint = 5'd1; exc_code = 5'd0;
    mpc = 32'h6000; mbd = 0; wdata = '0; bad_vaddr = '0;
    #2;
    reset = 1;
    model_reset();
    z = '0;
    sb.push_back(z);
    drive(1, 2'd1, 5'd12, 32'd0, 5'd1, 5'd0, 32'd0, 32'h6000, 0);
    mfc0(12); mfc0(14); mfc0(13);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  o;
      logic [4:0]  rid, hw, ex;
      logic [31:0] wd;
      int r;
      r = $urandom_range(0, 11);
      o = (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : (r < 11) ? 2'd3 : 2'd0;
      rid = rtab[$urandom_range(0, 8)];
      wd = $urandom;
      if (rid == 5'd9 && $urandom_range(0, 1) == 1) wd = m_cmp - 32'($urandom_range(0, 4));
      if (rid == 5'd12 && $urandom_range(0, 3) != 0) wd = wd | 32'h1;
      hw = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      ex = 5'd0;
      if ($urandom_range(0, 9) == 0) ex = ($urandom_range(0, 1) == 1) ? 5'(4 + $urandom_range(0, 1))
                                                                      : 5'($urandom_range(1, 31));
      drive(0, o, rid, wd, hw, ex, $urandom, $urandom, 1'($urandom));
    end

    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
